// File: rtl/ddfs_pkg.sv
// Shared definitions for the DDFS waveform generator: waveform encodings,
// output mid-scale helper and the fixed pipeline latency.
package ddfs_pkg;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'b00,
    MODE_SQUARE = 2'b01,
    MODE_TRI    = 2'b10,
    MODE_SAW    = 2'b11
  } mode_e;

  // Accumulator-to-output delay in clock cycles.
  localparam int LATENCY = 3;

  // Offset-binary zero level for a w-bit DAC sample.
  function automatic int unsigned mid_scale(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/ddfs_wave_gen_lut.sv
// Quarter-wave sine magnitude table with a registered read. Entries are
// sampled at half-index offsets, so the quarter mirrors cleanly into a full
// wave without repeating the peak or zero sample.
module sin_quarter_lut #(
  parameter int DATA_WIDTH = 12,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_WIDTH-1:0]  idx_i,
  output logic [DATA_WIDTH-2:0] mag_o
);

  localparam int DEPTH = 1 << IDX_WIDTH;

  // round(AMP * sin(pi/2 * (i+0.5)/DEPTH)), evaluated at elaboration with a
  // Q30 Taylor series so no real arithmetic reaches synthesis.
  function automatic logic [DATA_WIDTH-2:0] lut_entry(input int i);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint amp;
    x    = (64'sd1686629713 * longint'(2 * i + 1)) / longint'(2 * DEPTH);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k <= 8; k++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1)));
      sum  = sum + term;
    end
    amp = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
    return (DATA_WIDTH - 1)'((amp * sum + (64'sd1 <<< 29)) >>> 30);
  endfunction

  logic [DATA_WIDTH-2:0] rom [DEPTH];
  logic [DATA_WIDTH-2:0] mag_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic [DATA_WIDTH-2:0] ENTRY = lut_entry(g);
    assign rom[g] = ENTRY;
  end

  // Registered table read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mag_q <= '0;
    else        mag_q <= rom[idx_i];
  end

  assign mag_o = mag_q;

endmodule

// File: rtl/ddfs_wave_gen.sv
// Direct digital frequency synthesiser: phase accumulator with wrap-deferred
// parameter updates, followed by a 3-stage waveform pipeline (phase/mode,
// LUT read + tags, output mux). q holds its last value on invalid slots.
module ddfs_wave_gen
  import ddfs_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int ADDR_WIDTH  = 10,
  parameter int PHASE_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   load,
  input  logic [PHASE_WIDTH-1:0] fcw_in,
  input  logic [PHASE_WIDTH-1:0] phase_off_in,
  input  logic [1:0]             mode_in,
  output logic [DATA_WIDTH-1:0]  q,
  output logic                   q_valid,
  output logic                   wrap
);

  localparam int IDX_WIDTH = ADDR_WIDTH - 2;
  localparam logic [DATA_WIDTH-1:0] MID = DATA_WIDTH'(mid_scale(DATA_WIDTH));

  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic [PHASE_WIDTH-1:0] fcw_act_q, fcw_act_d, off_act_q, off_act_d;
  logic [PHASE_WIDTH-1:0] fcw_pend_q, fcw_pend_d, off_pend_q, off_pend_d;
  mode_e                  mode_act_q, mode_act_d, mode_pend_q, mode_pend_d;
  logic                   pend_vld_q, pend_vld_d;
  logic                   wflag_q, wflag_d;
  logic [PHASE_WIDTH:0]   acc_sum;
  logic                   wrap_evt;

  assign acc_sum  = {1'b0, acc_q} + {1'b0, fcw_act_q};
  assign wrap_evt = en & acc_sum[PHASE_WIDTH];

  // Accumulator step and pending/active parameter hand-over.
  always_comb begin
    acc_d       = acc_q;
    wflag_d     = wflag_q;
    fcw_act_d   = fcw_act_q;
    off_act_d   = off_act_q;
    mode_act_d  = mode_act_q;
    fcw_pend_d  = fcw_pend_q;
    off_pend_d  = off_pend_q;
    mode_pend_d = mode_pend_q;
    pend_vld_d  = pend_vld_q;
    if (en) begin
      acc_d   = acc_sum[PHASE_WIDTH-1:0];
      wflag_d = acc_sum[PHASE_WIDTH];
    end
    if (wrap_evt && load) begin
      // A load landing on the wrap goes live at once; older pending is dropped.
      fcw_act_d  = fcw_in;
      off_act_d  = phase_off_in;
      mode_act_d = mode_e'(mode_in);
      pend_vld_d = 1'b0;
    end else begin
      if ((wrap_evt || !en) && pend_vld_q) begin
        fcw_act_d  = fcw_pend_q;
        off_act_d  = off_pend_q;
        mode_act_d = mode_pend_q;
        pend_vld_d = 1'b0;
      end
      if (load) begin
        fcw_pend_d  = fcw_in;
        off_pend_d  = phase_off_in;
        mode_pend_d = mode_e'(mode_in);
        pend_vld_d  = 1'b1;
      end
    end
  end

  // Accumulator and parameter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      wflag_q     <= 1'b0;
      fcw_act_q   <= '0;
      off_act_q   <= '0;
      mode_act_q  <= MODE_SINE;
      fcw_pend_q  <= '0;
      off_pend_q  <= '0;
      mode_pend_q <= MODE_SINE;
      pend_vld_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      wflag_q     <= wflag_d;
      fcw_act_q   <= fcw_act_d;
      off_act_q   <= off_act_d;
      mode_act_q  <= mode_act_d;
      fcw_pend_q  <= fcw_pend_d;
      off_pend_q  <= off_pend_d;
      mode_pend_q <= mode_pend_d;
      pend_vld_q  <= pend_vld_d;
    end
  end

  // Valid and wrap flags travel LATENCY cycles alongside the sample.
  logic [LATENCY-1:0] vld_sr_q, wrap_sr_q;

  // Sample flag delay lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr_q  <= '0;
      wrap_sr_q <= '0;
    end else begin
      vld_sr_q  <= {vld_sr_q[LATENCY-2:0], en};
      wrap_sr_q <= {wrap_sr_q[LATENCY-2:0], en & wflag_q};
    end
  end

  // ---- stage 1: phase and mode ----
  logic [PHASE_WIDTH-1:0] p_p1_q;
  mode_e                  mode_p1_q;

  // Register offset phase with the mode it must be rendered in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_p1_q    <= '0;
      mode_p1_q <= MODE_SINE;
    end else begin
      p_p1_q    <= acc_q + off_act_q;
      mode_p1_q <= mode_act_q;
    end
  end

  // ---- stage 2: LUT read, quadrant/mode tag, non-sine value ----
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [IDX_WIDTH-1:0]  lut_idx;
  logic [DATA_WIDTH-1:0] alt_d;
  logic [DATA_WIDTH-2:0] mag_p2;
  logic [DATA_WIDTH-1:0] alt_p2_q;
  logic                  qhi_p2_q;
  mode_e                 mode_p2_q;
  logic                  unused_phase;

  assign addr_p1      = p_p1_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign lut_idx      = addr_p1[ADDR_WIDTH-2] ? ~addr_p1[IDX_WIDTH-1:0]
                                              : addr_p1[IDX_WIDTH-1:0];
  assign unused_phase = ^p_p1_q;

  // Square, triangle and sawtooth come straight from the phase bits.
  always_comb begin
    alt_d = MID;
    case (mode_p1_q)
      MODE_SQUARE: alt_d = p_p1_q[PHASE_WIDTH-1] ? '0 : '1;
      MODE_TRI:    alt_d = p_p1_q[PHASE_WIDTH-1] ? ~p_p1_q[PHASE_WIDTH-2 -: DATA_WIDTH]
                                                 :  p_p1_q[PHASE_WIDTH-2 -: DATA_WIDTH];
      MODE_SAW:    alt_d = p_p1_q[PHASE_WIDTH-1 -: DATA_WIDTH];
      default:     alt_d = MID;
    endcase
  end

  sin_quarter_lut #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .idx_i (lut_idx),
    .mag_o (mag_p2)
  );

  // Tags that accompany the LUT read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qhi_p2_q  <= 1'b0;
      mode_p2_q <= MODE_SINE;
      alt_p2_q  <= MID;
    end else begin
      qhi_p2_q  <= addr_p1[ADDR_WIDTH-1];
      mode_p2_q <= mode_p1_q;
      alt_p2_q  <= alt_d;
    end
  end

  // ---- stage 3: output mux ----
  logic [DATA_WIDTH-1:0] sine_p2;
  logic [DATA_WIDTH-1:0] q_q, q_d;

  assign sine_p2 = qhi_p2_q ? (MID - DATA_WIDTH'(1) - {1'b0, mag_p2})
                            : (MID + {1'b0, mag_p2});

  // Pick the waveform; hold the previous sample on invalid slots.
  always_comb begin
    q_d = q_q;
    if (vld_sr_q[LATENCY-2]) q_d = (mode_p2_q == MODE_SINE) ? sine_p2 : alt_p2_q;
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= MID;
    else        q_q <= q_d;
  end

  assign q       = q_q;
  assign q_valid = vld_sr_q[LATENCY-1];
  assign wrap    = wrap_sr_q[LATENCY-1];

endmodule
